prbs16_checker: RTL

Serial receive-side checker for the 16-bit Fibonacci PRBS produced by the team's LFSR generator (polynomial x^16 + x^14 + x^13 + x^11 + 1, left shift, feedback into bit 0). It consumes one bit per enabled cycle and self-synchronises to the stream with no seed exchange. Once locked, it flags and counts bit errors. It sits at the far end of a serial link or loopback path, opposite the generator, for link BER testing.

---
 rtl/prbs16_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the x^16+x^14+x^13+x^11+1 PRBS.
// It hunts for alignment on the received bits, then free-runs and flags and counts bit errors.
module prbs16_checker #(
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 8,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic             sync_loss,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_nx;
  logic [15:0]      sr, sr_nx;
  logic [4:0]       fill, fill_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [LW-1:0]    miss_cnt, miss_nx;
  logic             err_nx, loss_nx;
  logic [ERR_W-1:0] err_count_nx;
  logic             pred;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pred   = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= HUNT;
      sr        <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err       <= 1'b0;
      sync_loss <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      fill      <= fill_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      err       <= err_nx;
      sync_loss <= loss_nx;
      err_count <= err_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    fill_nx      = fill;
    match_nx     = match_cnt;
    miss_nx      = miss_cnt;
    err_nx       = 1'b0;
    loss_nx      = 1'b0;
    err_count_nx = err_count;

    if (enable) begin
      case (state)
        HUNT: begin
          sr_nx = {sr[14:0], din};
          if (fill < 5'd16) begin
            fill_nx = fill + 5'd1;
          end else if ((pred == din) && (sr != 16'h0000)) begin
            // An all-zero register would predict zeros forever, so it never counts.
            match_nx = match_cnt + 1'b1;
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          // Free-running on the prediction keeps one bad bit from spoiling later ones.
          sr_nx = {sr[14:0], pred};
          if (din != pred) begin
            err_nx       = 1'b1;
            err_count_nx = sat_inc(err_count);
            miss_nx      = miss_cnt + 1'b1;
            if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
              state_nx = HUNT;
              loss_nx  = 1'b1;
              fill_nx  = '0;
              match_nx = '0;
            end
          end else begin
            miss_nx = '0;
          end
        end
        default: state_nx = HUNT;
      endcase
    end

    if (clr_err) err_count_nx = '0;
  end

endmodule
